block_aligner: RTL and testbench



---
 rtl/block_aligner.sv | 112 +++++++++++
 tb/tb_block_aligner.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/block_aligner.sv
// Collects N sign/mantissa/exponent operands, finds the block max exponent and
// re-emits each operand as a 20-bit two's-complement value aligned to that max.
module block_aligner #(
    parameter int N = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [10:0] in_mant,
    input  logic [5:0]  in_exp,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [19:0] out_data,
    output logic [5:0]  out_exp_max,
    output logic        out_last
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {COLLECT, EMIT} state_t;

    state_t          state;
    logic [CW-1:0]   wr_cnt, rd_cnt, rd_nxt;
    logic [5:0]      cur_max, blk_max;
    logic            have_max;
    logic            accept, xfer, nz, take;

    logic            buf_sign [N];
    logic [10:0]     buf_mant [N];
    logic [5:0]      buf_exp  [N];

    // Exponent gap is taken mod 128; zero operands may wrap but shift out to 0.
    function automatic logic [19:0] align(input logic s, input logic [10:0] m,
                                          input logic [5:0] e, input logic [5:0] mx);
        logic [6:0]  d;
        logic [19:0] mag;
        d   = {mx[5], mx} - {e[5], e};
        mag = (d >= 7'd11) ? 20'd0 : {9'd0, m >> d};
        return s ? (20'd0 - mag) : mag;
    endfunction

    assign accept  = in_valid && in_ready;
    assign xfer    = out_valid && out_ready;
    assign nz      = (in_mant != 11'd0);
    assign take    = nz && (!have_max || ($signed(in_exp) > $signed(cur_max)));
    assign blk_max = take ? in_exp : cur_max;
    assign rd_nxt  = rd_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (accept) begin
            buf_sign[wr_cnt] <= in_sign;
            buf_mant[wr_cnt] <= in_mant;
            buf_exp[wr_cnt]  <= in_exp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= COLLECT;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            cur_max     <= '0;
            have_max    <= 1'b0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_exp_max <= '0;
            out_last    <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (accept) begin
                        wr_cnt   <= wr_cnt + 1'b1;
                        cur_max  <= blk_max;
                        have_max <= have_max | nz;
                        if (wr_cnt == CW'(N - 1)) begin
                            // Buffer slot 0 was written on an earlier cycle, so it is readable now.
                            wr_cnt      <= '0;
                            cur_max     <= '0;
                            have_max    <= 1'b0;
                            out_exp_max <= blk_max;
                            out_data    <= align(buf_sign[0], buf_mant[0], buf_exp[0], blk_max);
                            out_last    <= 1'b0;
                            out_valid   <= 1'b1;
                            in_ready    <= 1'b0;
                            state       <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    if (xfer) begin
                        if (rd_cnt == CW'(N - 1)) begin
                            rd_cnt    <= '0;
                            out_data  <= '0;
                            out_last  <= 1'b0;
                            out_valid <= 1'b0;
                            in_ready  <= 1'b1;
                            state     <= COLLECT;
                        end else begin
                            rd_cnt   <= rd_nxt;
                            out_data <= align(buf_sign[rd_nxt], buf_mant[rd_nxt],
                                              buf_exp[rd_nxt], out_exp_max);
                            out_last <= (rd_nxt == CW'(N - 1));
                        end
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end
endmodule

// File: tb/tb_block_aligner.sv
// Randomized bench for block_aligner: a queue-based block model predicts every
// output; directed blocks also pin observed outputs to hand-computed literals.
module tb_block_aligner;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [10:0] in_mant = '0;
    logic [5:0]  in_exp = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [19:0] out_data;
    logic [5:0]  out_exp_max;
    logic        out_last;

    block_aligner #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_mant(in_mant), .in_exp(in_exp),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_exp_max(out_exp_max), .out_last(out_last)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic s; logic [10:0] m; logic [5:0] e; } op_t;
    typedef struct packed { logic [19:0] d; logic [5:0] x; logic l; } res_t;

    op_t         blk[$];
    res_t        exp_q[$];
    logic [19:0] obs_d[$];
    logic [5:0]  obs_x[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          rnd_ready = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference: plain integer arithmetic over a whole collected block.
    function automatic void build();
        int mx = 0;
        bit any = 0;
        foreach (blk[i]) begin
            int e;
            e = $signed(blk[i].e);
            if (blk[i].m != 0) begin
                if (!any || e > mx) mx = e;
                any = 1;
            end
        end
        foreach (blk[i]) begin
            int d, mag;
            res_t r;
            d   = mx - $signed(blk[i].e);
            mag = (blk[i].m == 0 || d >= 11) ? 0 : (int'(blk[i].m) >> d);
            r.d = blk[i].s ? 20'(-mag) : 20'(mag);
            r.x = 6'(mx);
            r.l = (i == N - 1);
            exp_q.push_back(r);
        end
        blk.delete();
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_data", out_data, 0);
            chk("rst_out_last", out_last, 0);
            chk("rst_out_exp_max", out_exp_max, 0);
            blk.delete();
            exp_q.delete();
        end else begin
            chk("in_ready", in_ready, exp_q.size() == 0);
            chk("out_valid", out_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                chk("out_data", out_data, exp_q[0].d);
                chk("out_exp_max", out_exp_max, exp_q[0].x);
                chk("out_last", out_last, exp_q[0].l);
                if (out_ready) begin
                    obs_d.push_back(out_data);
                    obs_x.push_back(out_exp_max);
                    void'(exp_q.pop_front());
                end
            end else if (in_valid) begin
                blk.push_back('{in_sign, in_mant, in_exp});
                if (blk.size() == N) build();
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_op(input logic s, input logic [10:0] m, input logic [5:0] e);
        bit acc = 0;
        in_valid = 1'b1; in_sign = s; in_mant = m; in_exp = e;
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
        end
        chk("send_accept", acc, 1);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) tick();
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic check_lits(input string nm, input logic [19:0] d0, input logic [19:0] d1,
                              input logic [19:0] d2, input logic [19:0] d3, input logic [5:0] x);
        logic [19:0] ed [4];
        ed[0] = d0; ed[1] = d1; ed[2] = d2; ed[3] = d3;
        chk({nm, "_count"}, obs_d.size(), 4);
        for (int i = 0; i < 4 && i < obs_d.size(); i++) begin
            chk({nm, "_data"}, obs_d[i], ed[i]);
            chk({nm, "_exp"}, obs_x[i], x);
        end
        obs_d.delete();
        obs_x.delete();
    endtask

    initial begin
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Alignment and sign
        send_op(0, 11'h400, 6'd3);  send_op(0, 11'h400, 6'd1);
        send_op(1, 11'h600, 6'd3);  send_op(0, 11'h7FF, 6'h3E);
        drain();
        check_lits("t1", 20'h00400, 20'h00100, 20'hFFA00, 20'h0003F, 6'd3);

        // Shift boundaries
        send_op(0, 11'h400, 6'd10); send_op(0, 11'h400, 6'd0);
        send_op(0, 11'h400, 6'h3F); send_op(1, 11'h7FF, 6'h20);
        drain();
        check_lits("t2", 20'h00400, 20'h00001, 20'h00000, 20'h00000, 6'd10);

        // All-zero block, then a zero operand with a large exponent
        send_op(1, 11'h000, 6'd5);  send_op(1, 11'h000, 6'h39);
        send_op(1, 11'h000, 6'd31); send_op(1, 11'h000, 6'd0);
        drain();
        check_lits("t3", 20'h0, 20'h0, 20'h0, 20'h0, 6'd0);
        send_op(0, 11'h000, 6'd31); send_op(0, 11'h400, 6'd2);
        send_op(0, 11'h400, 6'd1);  send_op(1, 11'h100, 6'd2);
        drain();
        check_lits("t3b", 20'h0, 20'h00400, 20'h00200, 20'hFFF00, 6'd2);

        // Backpressure on the 2nd output with in_valid held high
        send_op(0, 11'h400, 6'd4);  send_op(0, 11'h400, 6'd2);
        send_op(1, 11'h7FF, 6'd3);  send_op(0, 11'h123, 6'd4);
        in_sign = 1'b0; in_mant = 11'h555; in_exp = 6'd30;
        tick();
        out_ready = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
        drain();
        check_lits("t4", 20'h00400, 20'h00100, 20'hFFC01, 20'h00123, 6'd4);

        // Reset mid-collect
        send_op(0, 11'h400, 6'd20); send_op(1, 11'h300, 6'd20);
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        send_op(0, 11'h400, 6'd4);  send_op(0, 11'h400, 6'd2);
        send_op(1, 11'h7FF, 6'd3);  send_op(0, 11'h123, 6'd4);
        drain();
        check_lits("t5", 20'h00400, 20'h00100, 20'hFFC01, 20'h00123, 6'd4);

        // Back-to-back blocks, in_valid continuously high
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < N; i++)
                send_op(1'($urandom_range(0, 1)), 11'($urandom_range(1, 2047)),
                        6'($urandom_range(0, 63)));
        drain();

        // Random operands, random gaps, random backpressure
        rnd_ready = 1'b1;
        for (int b = 0; b < 40; b++)
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    in_valid = 1'b0;
                    tick();
                end
                send_op(1'($urandom_range(0, 1)),
                        ($urandom_range(0, 4) == 0) ? 11'd0 : 11'($urandom_range(0, 2047)),
                        ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 63))
                                                    : 6'($urandom_range(0, 12) - 6));
            end
        drain();
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
